// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame geometry
// used by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned DEFAULT_DATA_BITS  = 8;
    localparam int unsigned DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// The reset value is a parameter so an idle-high line does not look like an edge.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start-bit qualification, LSB-first data capture
// and stop-bit check, with one-cycle done / frame-error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic                 w_rx_s;
    logic                 r_rx_prev;
    uart_state_e          r_state;
    uart_state_e          w_state_next;
    logic [TICK_W-1:0]    r_tick_cnt;
    logic [TICK_W-1:0]    w_tick_cnt_next;
    logic [TICK_W-1:0]    w_tick_inc;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [BIT_W-1:0]     w_bit_cnt_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_done;
    logic                 r_frame_err;
    logic                 w_load;
    logic                 w_ferr;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .i_d(rx),
        .o_q(w_rx_s)
    );

    assign w_tick_inc = (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_rx_prev  <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_tick_cnt <= w_tick_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_shift    <= w_shift_next;
            r_rx_prev  <= w_rx_s;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_tick_cnt_next = r_tick_cnt;
        w_bit_cnt_next  = r_bit_cnt;
        w_shift_next    = r_shift;
        w_load          = 1'b0;
        w_ferr          = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_tick_cnt_next = '0;
                w_bit_cnt_next  = '0;
                // Edge rule: a line stuck low after a bad frame never restarts reception.
                if (r_rx_prev && !w_rx_s) begin
                    w_state_next = StStart;
                end
            end
            StStart: begin
                if (baud_tick) begin
                    if (r_tick_cnt == TICK_MID) begin
                        w_tick_cnt_next = '0;
                        w_state_next    = w_rx_s ? StIdle : StData;
                    end else begin
                        w_tick_cnt_next = w_tick_inc;
                    end
                end
            end
            StData: begin
                if (baud_tick) begin
                    w_tick_cnt_next = w_tick_inc;
                    if (r_tick_cnt == TICK_LAST) begin
                        w_shift_next = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == BIT_LAST) begin
                            w_state_next = StStop;
                        end else begin
                            w_bit_cnt_next = r_bit_cnt + 1'b1;
                        end
                    end
                end
            end
            StStop: begin
                if (baud_tick) begin
                    w_tick_cnt_next = w_tick_inc;
                    // Leaving at mid stop bit leaves half a bit to catch a back-to-back start.
                    if (r_tick_cnt == TICK_LAST) begin
                        w_state_next = StIdle;
                        w_load       = w_rx_s;
                        w_ferr       = !w_rx_s;
                    end
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_data   <= '0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_done   <= w_load;
            r_frame_err <= w_ferr;
            if (w_load) begin
                r_rx_data <= r_shift;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_done   = r_rx_done;
    assign frame_err = r_frame_err;
    assign rx_busy   = (r_state != StIdle);

endmodule
